// File: rtl/mma_tile_sequencer.sv
// Tiled GEMM job sequencer: walks an Mt x Nt x Kt tile space (k innermost),
// issues tile commands under an in-flight credit limit and retires engine results.
module mma_tile_sequencer #(
    parameter int DIM_W   = 8,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 2*DIM_W+DIM_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [DIM_W-1:0] cfg_mt_i,
    input  logic [DIM_W-1:0] cfg_nt_i,
    input  logic [DIM_W-1:0] cfg_kt_i,
    input  logic             cfg_halved_i,
    output logic             issue_valid_o,
    input  logic             issue_ready_i,
    output logic [DIM_W-1:0] issue_m_o,
    output logic [DIM_W-1:0] issue_n_o,
    output logic [DIM_W-1:0] issue_k_o,
    output logic             issue_first_o,
    output logic             issue_last_o,
    output logic             halved_precision_o,
    input  logic             resp_valid_i,
    output logic             resp_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int OUT_W = $clog2(MAX_OUT+1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   mt_q, mt_d, nt_q, nt_d, kt_q, kt_d;
    logic [DIM_W-1:0]   m_q, m_d, n_q, n_d, k_q, k_d;
    logic               halved_q, halved_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               issue_fire, resp_fire;
    logic               k_wrap, n_wrap, m_wrap;

    // Credit gate looks at the registered count only; a response this cycle frees
    // a slot for the next cycle, never the current one.
    assign issue_valid_o = (state_q == S_ISSUE) && (out_q < OUT_W'(MAX_OUT));
    assign resp_ready_o  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign busy_o        = resp_ready_o;
    assign cfg_ready_o   = (state_q == S_IDLE);
    assign done_o        = (state_q == S_DONE);

    assign issue_fire = issue_valid_o && issue_ready_i;
    assign resp_fire  = resp_valid_i && resp_ready_o;

    assign k_wrap = (k_q == kt_q - DIM_W'(1));
    assign n_wrap = (n_q == nt_q - DIM_W'(1));
    assign m_wrap = (m_q == mt_q - DIM_W'(1));

    assign issue_m_o          = m_q;
    assign issue_n_o          = n_q;
    assign issue_k_o          = k_q;
    assign issue_first_o      = (k_q == '0);
    assign issue_last_o       = k_wrap;
    assign halved_precision_o = halved_q;
    assign retired_o          = retired_q;

    always_comb begin
        state_d   = state_q;
        mt_d      = mt_q;
        nt_d      = nt_q;
        kt_d      = kt_q;
        m_d       = m_q;
        n_d       = n_q;
        k_d       = k_q;
        halved_d  = halved_q;
        out_d     = out_q;
        retired_d = retired_q;

        unique case ({issue_fire, resp_fire})
            2'b10:   out_d = out_q + OUT_W'(1);
            2'b01:   out_d = out_q - OUT_W'(1);
            default: out_d = out_q;
        endcase
        if (resp_fire) begin
            retired_d = retired_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (cfg_valid_i) begin
                    mt_d      = cfg_mt_i;
                    nt_d      = cfg_nt_i;
                    kt_d      = cfg_kt_i;
                    halved_d  = cfg_halved_i;
                    m_d       = '0;
                    n_d       = '0;
                    k_d       = '0;
                    out_d     = '0;
                    retired_d = '0;
                    if (cfg_mt_i == '0 || cfg_nt_i == '0 || cfg_kt_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_fire) begin
                    if (!k_wrap) begin
                        k_d = k_q + DIM_W'(1);
                    end else begin
                        k_d = '0;
                        if (!n_wrap) begin
                            n_d = n_q + DIM_W'(1);
                        end else begin
                            n_d = '0;
                            if (m_wrap) begin
                                state_d = S_DRAIN;
                            end else begin
                                m_d = m_q + DIM_W'(1);
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (out_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            mt_q      <= '0;
            nt_q      <= '0;
            kt_q      <= '0;
            m_q       <= '0;
            n_q       <= '0;
            k_q       <= '0;
            halved_q  <= 1'b0;
            out_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            mt_q      <= mt_d;
            nt_q      <= nt_d;
            kt_q      <= kt_d;
            m_q       <= m_d;
            n_q       <= n_d;
            k_q       <= k_d;
            halved_q  <= halved_d;
            out_q     <= out_d;
            retired_q <= retired_d;
        end
    end

endmodule
